ctl_multi: RTL and testbench

//  Parametrised successor to the single-channel stopwatch control FSM.

---
 rtl/ctl_pkg.sv | 24 ++
 rtl/ctl_if.sv | 22 ++
 rtl/ctl_channel.sv | 90 +++++++++
 rtl/ctl_multi.sv | 35 +++
 tb/tb_ctl_multi.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ctl_pkg.sv
// Shared definitions for the multi-channel stopwatch controller.
// State encoding and the state-to-output decode used by every channel.
package ctl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_COUNTING = 2'b01;
    localparam logic [1:0] ST_PAUSED   = 2'b10;
    localparam logic [1:0] ST_LAP      = 2'b11;

    // Returns {init_regs, count_enabled, display_freeze}
    function automatic logic [2:0] state_out(input logic [1:0] s);
        logic [2:0] o;
        o = 3'b100;
        case (s)
            ST_IDLE:     o = 3'b100;
            ST_COUNTING: o = 3'b010;
            ST_PAUSED:   o = 3'b000;
            ST_LAP:      o = 3'b011;
            default:     o = 3'b100;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctl_if.sv
// Per-channel request/status bundle for ctl_multi.
// master drives requests and observes status; slave is the controller.
interface ctl_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] lap;
    logic [NUM_CH-1:0] init_regs;
    logic [NUM_CH-1:0] count_enabled;
    logic [NUM_CH-1:0] display_freeze;
    logic              any_counting;

    modport master (
        output trig, lap,
        input  init_regs, count_enabled, display_freeze, any_counting
    );

    modport slave (
        input  trig, lap,
        output init_regs, count_enabled, display_freeze, any_counting
    );
endinterface

// File: rtl/ctl_channel.sv
// One stopwatch channel: event detect, IDLE/COUNTING/PAUSED/LAP FSM.
// Optional PAUSED auto-timeout when CTL_PAUSE_TIMEOUT_EN is defined.
module ctl_channel
    import ctl_pkg::*;
#(
    parameter int EDGE_TRIG   = 1,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic trig_i,
    input  logic lap_i,
    output logic init_o,
    output logic en_o,
    output logic frz_o
);

    logic [1:0] state_q, state_d;
    logic       trig_ev, lap_ev;
    logic       expired;

    if (EDGE_TRIG != 0) begin : g_edge
        logic trig_q, lap_q;
        // Previous input levels; loaded during reset too so a held input
        // does not look like a fresh edge at release
        always_ff @(posedge clk) begin
            trig_q <= trig_i;
            lap_q  <= lap_i;
        end
        assign trig_ev = trig_i & ~trig_q;
        assign lap_ev  = lap_i & ~lap_q;
    end else begin : g_level
        assign trig_ev = trig_i;
        assign lap_ev  = lap_i;
    end

`ifdef CTL_PAUSE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles spent in PAUSED, held at zero elsewhere
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_PAUSED) cnt_d = cnt_q + 1'b1;
    end

    // Pause counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (state_q == ST_PAUSED) &&
                     (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    assign expired = 1'b0;
`endif

    // Next-state selection; trig always outranks lap and timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_ev) state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
                if (trig_ev)     state_d = ST_PAUSED;
                else if (lap_ev) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (trig_ev)     state_d = ST_PAUSED;
                else if (lap_ev) state_d = ST_COUNTING;
            end
            ST_PAUSED: begin
                if (trig_ev)      state_d = ST_COUNTING;
                else if (expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign {init_o, en_o, frz_o} = state_out(state_q);

endmodule

// File: rtl/ctl_multi.sv
// NUM_CH independent stopwatch control channels plus any_counting.
// Optional pause timeout: define CTL_PAUSE_TIMEOUT_EN.
module ctl_multi #(
    parameter int NUM_CH      = 2,
    parameter int EDGE_TRIG   = 1,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clk,
    input  logic reset,
    ctl_if.slave bus
);

    logic [NUM_CH-1:0] init_v, en_v, frz_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ctl_channel #(
            .EDGE_TRIG   (EDGE_TRIG),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .trig_i (bus.trig[i]),
            .lap_i  (bus.lap[i]),
            .init_o (init_v[i]),
            .en_o   (en_v[i]),
            .frz_o  (frz_v[i])
        );
    end

    assign bus.init_regs      = init_v;
    assign bus.count_enabled  = en_v;
    assign bus.display_freeze = frz_v;
    assign bus.any_counting   = |en_v;

endmodule

// File: tb/tb_ctl_multi.sv
// Scoreboard bench for ctl_multi: edge-triggered 2-channel DUT
// and a level-triggered 1-channel DUT.
module tb_ctl_multi;

    localparam int I = 0;
    localparam int C = 1;
    localparam int P = 2;
    localparam int L = 3;

    logic clk;
    logic reset;

    ctl_if #(.NUM_CH(2)) bus_e ();
    ctl_if #(.NUM_CH(1)) bus_l ();

    ctl_multi #(.NUM_CH(2), .EDGE_TRIG(1), .TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_e.slave)
    );

    ctl_multi #(.NUM_CH(1), .EDGE_TRIG(0), .TIMEOUT_CYC(8)) dut_lvl (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         stp;
        logic [6:0] exp;
    } sb_t;

    sb_t q[$];
    int  total  = 0;
    int  passed = 0;
    int  stp_n  = 0;

    // {init, en, freeze} for a channel in state s
    function automatic logic [2:0] dec(input int s);
        case (s)
            I:       return 3'b100;
            C:       return 3'b010;
            P:       return 3'b000;
            default: return 3'b011;
        endcase
    endfunction

    task automatic step(input logic r, input logic [1:0] t,
                        input logic [1:0] l, input int s0, input int s1);
        logic [2:0] o0, o1;
        sb_t e;
        @(negedge clk);
        reset = r;
        bus_e.trig = t;
        bus_e.lap  = l;
        o0 = dec(s0);
        o1 = dec(s1);
        e.id  = 0;
        e.stp = stp_n;
        e.exp = {o1[2], o0[2], o1[1], o0[1], o1[0], o0[0], o1[1] | o0[1]};
        q.push_back(e);
        stp_n++;
    endtask

    task automatic lstep(input logic r, input logic t, input logic l,
                         input int s);
        logic [2:0] o;
        sb_t e;
        @(negedge clk);
        reset = r;
        bus_l.trig = t;
        bus_l.lap  = l;
        o = dec(s);
        e.id  = 1;
        e.stp = stp_n;
        e.exp = {3'b000, o, o[1]};
        q.push_back(e);
        stp_n++;
    endtask

    // Monitor: one expectation per clock edge, sampled after the edge
    always begin
        sb_t e;
        logic [6:0] act;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.id == 0)
                act = {bus_e.init_regs, bus_e.count_enabled,
                       bus_e.display_freeze, bus_e.any_counting};
            else
                act = {3'b000, bus_l.init_regs, bus_l.count_enabled,
                       bus_l.display_freeze, bus_l.any_counting};
            total++;
            if (act === e.exp) passed++;
            else $display("FAIL dut%0d step %0d: got %b want %b",
                          e.id, e.stp, act, e.exp);
        end
    end

    initial begin
        reset = 1'b1;
        bus_e.trig = '0;
        bus_e.lap  = '0;
        bus_l.trig = '0;
        bus_l.lap  = '0;

        // reset and idle; lap ignored in IDLE
        step(1, 2'b00, 2'b00, I, I);
        step(1, 2'b00, 2'b00, I, I);
        step(0, 2'b00, 2'b00, I, I);
        step(0, 2'b00, 2'b11, I, I);
        step(0, 2'b00, 2'b00, I, I);

        // held trig gives a single start
        repeat (5) step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b01, 2'b00, P, I);
        step(0, 2'b00, 2'b00, P, I);

        // lap / split behaviour
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b00, 2'b01, L, I);
        step(0, 2'b00, 2'b00, L, I);
        step(0, 2'b00, 2'b01, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b01, 2'b01, P, I);
        step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b00, 2'b01, P, I);
        step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b00, 2'b01, L, I);
        step(0, 2'b00, 2'b00, L, I);
        step(0, 2'b01, 2'b00, P, I);
        step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);

        // channel 1 independent of channel 0
        step(0, 2'b10, 2'b00, C, C);
        step(0, 2'b00, 2'b00, C, C);
        step(0, 2'b00, 2'b10, C, L);
        step(0, 2'b00, 2'b00, C, L);

        // reset from LAP / PAUSED, trig held across release
        step(0, 2'b00, 2'b01, L, L);
        step(0, 2'b00, 2'b00, L, L);
        step(0, 2'b10, 2'b00, L, P);
        step(0, 2'b00, 2'b00, L, P);
        step(1, 2'b11, 2'b00, I, I);
        step(0, 2'b11, 2'b00, I, I);
        step(0, 2'b11, 2'b00, I, I);
        step(0, 2'b00, 2'b00, I, I);

        // pause duration behaviour
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b01, 2'b00, P, I);
`ifdef CTL_PAUSE_TIMEOUT_EN
        repeat (7) step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b00, 2'b00, I, I);
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
        step(0, 2'b01, 2'b00, P, I);
        step(0, 2'b00, 2'b00, P, I);
        repeat (6) step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
`else
        repeat (12) step(0, 2'b00, 2'b00, P, I);
        step(0, 2'b01, 2'b00, C, I);
        step(0, 2'b00, 2'b00, C, I);
`endif

        // level-triggered legacy toggle
        lstep(1, 0, 0, I);
        lstep(0, 1, 0, C);
        lstep(0, 1, 0, P);
        lstep(0, 1, 0, C);
        lstep(0, 1, 0, P);
        lstep(0, 0, 0, P);
        lstep(0, 0, 1, P);
        lstep(0, 1, 0, C);
        lstep(0, 0, 1, L);
        lstep(0, 0, 1, C);
        lstep(0, 0, 0, C);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d left want 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
